// File: rtl/shape_row_sequencer_if.sv
// Row output channel from the shape row sequencer to the display row writer.
// A row transfers on a rising edge where row_valid and row_ready are both 1.
// While row_valid=1 and row_ready=0 the master keeps row_index, row_data and
// row_empty stable. row_valid never drops until the row has been taken,
// except on an abort.
interface shape_row_sequencer_if #(
    parameter int WIDTH  = 51,
    parameter int ADDR_W = 6
);
    logic              row_valid;
    logic              row_ready;
    logic [ADDR_W-1:0] row_index;
    logic [WIDTH-1:0]  row_data;
    logic              row_empty;

    modport master (
        output row_valid, row_index, row_data, row_empty,
        input  row_ready
    );

    modport slave (
        input  row_valid, row_index, row_data, row_empty,
        output row_ready
    );
endinterface

// File: rtl/shape_row_sequencer.sv
// Shape ROM frame reader. On start it sweeps ROM rows 0..ROWS-1 for one
// orientation, hides the one-cycle ROM latency behind a 2-entry row FIFO and
// streams the rows to the display writer with full backpressure.
// rom_address is driven combinationally in the issuing cycle so that the ROM
// registers it on that edge and returns the word in the following cycle.
module shape_row_sequencer #(
    parameter int ROWS     = 60,
    parameter int WIDTH    = 51,
    parameter int ADDR_W   = 6,
    parameter int ORIENT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ORIENT_W-1:0] orientation_in,
    output logic [ORIENT_W-1:0] rom_orientation,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [WIDTH-1:0]    rom_data,
    shape_row_sequencer_if.master row,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   issue_cnt_q;
    logic [ADDR_W-1:0]   addr_q;       // last issued address, also the tag of the in-flight word
    logic                inflight_q;
    logic [ORIENT_W-1:0] orient_q;
    logic [WIDTH-1:0]    fifo_data_q [2];
    logic [ADDR_W-1:0]   fifo_idx_q  [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;

    logic       accept_start, issue, push, pop, flush;
    logic [2:0] slots_used;

    // A pop on this edge frees its slot in time for the word issued now,
    // which is what lets rows stream at one per cycle.
    assign pop        = (count_q != 2'd0) && row.row_ready;
    assign push       = inflight_q;
    assign flush      = abort && (state_q != IDLE);
    assign slots_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Next-state and issue decision; abort wins over start and issuing.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        issue        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    accept_start = 1'b1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (slots_used < 3'd2) begin
                    issue = 1'b1;
                    if (issue_cnt_q == LAST_ROW) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) state_d = IDLE;
                else if (slots_used == 3'd0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, orientation, issue counter and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            orient_q    <= '0;
            issue_cnt_q <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept_start) begin
                orient_q    <= orientation_in;
                issue_cnt_q <= '0;
            end else if (issue && (issue_cnt_q != LAST_ROW)) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (issue) addr_q <= issue_cnt_q;
        end
    end

    // Two-entry row FIFO: push the returning ROM word, pop on handshake, flush on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= '0;
            fifo_idx_q[1]  <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rom_data;
                fifo_idx_q[wr_ptr_q]  <= addr_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rom_orientation = orient_q;
    assign rom_address     = issue ? issue_cnt_q : addr_q;
    assign busy            = (state_q == FETCH) || (state_q == DRAIN);
    assign done            = (state_q == DONE);
    assign state_dbg       = state_q;

    assign row.row_valid = (count_q != 2'd0);
    assign row.row_index = fifo_idx_q[rd_ptr_q];
    assign row.row_data  = fifo_data_q[rd_ptr_q];
    assign row.row_empty = (fifo_data_q[rd_ptr_q] == '0);

endmodule

// File: tb/tb_shape_row_sequencer.sv
// Directed bench for shape_row_sequencer with a registered shape ROM model
// and an expected-row queue.
module tb_shape_row_sequencer;

    localparam int ROWS     = 60;
    localparam int WIDTH    = 51;
    localparam int ADDR_W   = 6;
    localparam int ORIENT_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ORIENT_W-1:0] orientation_in = '0;
    logic [ORIENT_W-1:0] rom_orientation;
    logic [ADDR_W-1:0]   rom_address;
    logic [WIDTH-1:0]    rom_data;
    logic                busy, done;
    logic [1:0]          state_dbg;

    shape_row_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) row_bus ();

    shape_row_sequencer #(
        .ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ORIENT_W(ORIENT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .orientation_in  (orientation_in),
        .rom_orientation (rom_orientation),
        .rom_address     (rom_address),
        .rom_data        (rom_data),
        .row             (row_bus),
        .busy            (busy),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    function automatic logic [WIDTH-1:0] rom_model(input logic [ORIENT_W-1:0] o,
                                                    input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (a == 6'd0)       v = 51'h0000002000000;   // bit 25 only
        else if (a == 6'd15) v = '1;
        else if (a == 6'd23) v = '0;
        else                 v = {o, 5'b10101, a, 36'h0A5A5C3C3};
        return v;
    endfunction

    always @(posedge clk) rom_data <= rom_model(rom_orientation, rom_address);

    // ---------------- scoreboard state ----------------
    logic [ADDR_W+WIDTH-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int t, acc, done_cnt, done_t, first_valid_t, last_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: apply row_ready, check the head against the queue,
    // then advance to just after the next rising edge.
    task automatic cycle(input logic rdy);
        logic [ADDR_W+WIDTH-1:0] e;
        row_bus.row_ready = rdy;
        #1;
        if (row_bus.row_valid) begin
            if (first_valid_t < 0) first_valid_t = t;
            if (exp_q.size() == 0) begin
                chk("extra_row", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                chk("row_index", 64'(row_bus.row_index), 64'(e[ADDR_W+WIDTH-1:WIDTH]));
                chk("row_data", 64'(row_bus.row_data), 64'(e[WIDTH-1:0]));
                chk("row_empty", 64'(row_bus.row_empty), 64'(e[WIDTH-1:0] == '0));
                if (rdy) begin
                    void'(exp_q.pop_front());
                    acc++;
                    if (e[ADDR_W+WIDTH-1:WIDTH] == ADDR_W'(ROWS - 1)) last_t = t;
                end
            end
        end
        if (busy) chk("addr_lead", 64'(int'(rom_address) <= acc + 2), 64'd1);
        if (done) begin
            done_cnt++;
            done_t = t;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_start(input logic [ORIENT_W-1:0] o);
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            exp_q.push_back({ADDR_W'(r), rom_model(o, ADDR_W'(r))});
        acc = 0; done_cnt = 0; done_t = -1; first_valid_t = -1; last_t = -1;
        orientation_in = o;
        start = 1'b1;
        cycle(1'b1);
        start = 1'b0;
        t = 0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_orient", 64'(rom_orientation), 64'(o));
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 10 cycles;
    // 3: ready high with stray starts and orientation toggling.
    task automatic run_frame(input int mode, input int budget);
        logic rdy;
        for (int n = 0; n < budget && done_cnt == 0; n++) begin
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (t >= 10);
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && t == 5) begin
                chk("stall_addr", 64'(rom_address), 64'd1);
                chk("stall_valid", 64'(row_bus.row_valid), 64'd1);
                chk("stall_index", 64'(row_bus.row_index), 64'd0);
            end
            if (mode == 3) begin
                start = (t == 10) || (t == 62);
                if (t >= 10) orientation_in = ~orientation_in;
            end
            cycle(rdy);
        end
        start = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic tail(input int exp_done);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_state", 64'(state_dbg), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        t = 0; acc = 0; done_cnt = 0; done_t = -1; first_valid_t = -1; last_t = -1;
        row_bus.row_ready = 1'b0;
        void'($urandom(32'd1234));

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 64'(rom_address), 64'd0);
        chk("rst_orient", 64'(rom_orientation), 64'd0);
        chk("rst_valid", 64'(row_bus.row_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full-rate frame, orientation 0
        do_start(4'd0);
        run_frame(0, 100);
        chk("first_valid_t", 64'(first_valid_t), 64'd2);
        chk("last_row_t", 64'(last_t), 64'd61);
        chk("done_t", 64'(done_t), 64'd62);
        tail(1);
        chk("rows_left_a", 64'(exp_q.size()), 64'd0);

        // random backpressure
        do_start(4'd5);
        run_frame(1, 400);
        tail(1);
        chk("rows_left_b", 64'(exp_q.size()), 64'd0);

        // ready held low for 10 cycles after start
        do_start(4'd2);
        run_frame(2, 200);
        tail(1);
        chk("rows_left_c", 64'(exp_q.size()), 64'd0);

        // abort with row 30 at the head
        do_start(4'd3);
        for (int n = 0; n < 100 && acc < 30; n++) cycle(1'b1);
        abort = 1'b1;
        chk("abort_head", 64'(row_bus.row_index), 64'd30);
        cycle(1'b0);
        abort = 1'b0;
        chk("abort_valid", 64'(row_bus.row_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        tail(0);
        do_start(4'd1);
        run_frame(0, 100);
        tail(1);
        chk("rows_left_d", 64'(exp_q.size()), 64'd0);

        // stray starts mid-frame and in the DONE cycle, orientation toggling
        do_start(4'd6);
        orientation_in = 4'd9;
        run_frame(3, 100);
        chk("stray_orient", 64'(rom_orientation), 64'd6);
        chk("stray_done_t", 64'(done_t), 64'd62);
        tail(1);
        chk("rows_left_e", 64'(exp_q.size()), 64'd0);

        // asynchronous reset at row 20, then a clean frame
        do_start(4'd4);
        for (int n = 0; n < 100 && acc < 20; n++) cycle(1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", 64'(rom_address), 64'd0);
        chk("mid_rst_orient", 64'(rom_orientation), 64'd0);
        chk("mid_rst_valid", 64'(row_bus.row_valid), 64'd0);
        chk("mid_rst_index", 64'(row_bus.row_index), 64'd0);
        chk("mid_rst_data", 64'(row_bus.row_data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(4'd7);
        run_frame(0, 100);
        chk("post_rst_first", 64'(first_valid_t), 64'd2);
        tail(1);
        chk("rows_left_f", 64'(exp_q.size()), 64'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
